// File: rtl/data_mem_arbiter.sv
// Two-port arbiter for the BIP single-port data memory: the CPU has priority, and a
// debug/loader request preempts the CPU for one cycle once it has waited MAX_WAIT cycles.
`timescale 1ns/1ps
module data_mem_arbiter #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11,
    parameter int ADDR_LIMIT = 10,
    parameter int MAX_WAIT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              oor_flag,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic              dbg_err,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] LIMIT    = ADDR_W'(ADDR_LIMIT);
    localparam logic [3:0]        WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DBG_ISSUE = 2'd1,
        DBG_ACK   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              dbg_err_q, dbg_err_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
    logic              oor_flag_q, oor_flag_d;

    logic cpu_req, dbg_pend, dbg_win, cpu_accept, cpu_oor, dbg_oor;

    // Grant decision; reset masks it so nothing is granted while the block is held in reset.
    always_comb begin
        cpu_req    = cpu_rd ^ cpu_wr;
        dbg_pend   = dbg_req && (state_q == RUN) && !reset;
        dbg_win    = dbg_pend && (!cpu_req || (wait_cnt_q == WAIT_MAX));
        cpu_accept = cpu_req && !dbg_win;
        cpu_oor    = (cpu_addr >= LIMIT);
        dbg_oor    = (dbg_addr >= LIMIT);
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        err_d       = err_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dbg_ack_d   = 1'b0;
        dbg_err_d   = dbg_err_q;
        dbg_rdata_d = dbg_rdata_q;
        oor_flag_d  = oor_flag_q;

        case (state_q)
            RUN: begin
                if (dbg_win) begin
                    state_d = DBG_ISSUE;
                end
            end
            DBG_ISSUE: begin
                // mem_rd_q is only set for an in-range debug read, so writes and errors return 0.
                state_d     = DBG_ACK;
                dbg_ack_d   = 1'b1;
                dbg_err_d   = err_q;
                dbg_rdata_d = mem_rd_q ? mem_rdata : '0;
            end
            DBG_ACK: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (dbg_win || !dbg_req) begin
            wait_cnt_d = 4'd0;
        end else if (dbg_pend && cpu_req && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end

        if (dbg_win) begin
            mem_addr_d  = dbg_addr;
            mem_wdata_d = dbg_wdata;
            mem_rd_d    = !dbg_we && !dbg_oor;
            mem_wr_d    = dbg_we && !dbg_oor;
            err_d       = dbg_oor;
        end else if (cpu_accept) begin
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            mem_rd_d    = cpu_rd && !cpu_oor;
            mem_wr_d    = cpu_wr && !cpu_oor;
            oor_flag_d  = oor_flag_q || cpu_oor;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            wait_cnt_q  <= 4'd0;
            err_q       <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            dbg_ack_q   <= 1'b0;
            dbg_err_q   <= 1'b0;
            dbg_rdata_q <= '0;
            oor_flag_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_err_q   <= dbg_err_d;
            dbg_rdata_q <= dbg_rdata_d;
            oor_flag_q  <= oor_flag_d;
        end
    end

    assign cpu_rdata = mem_rdata;
    assign cpu_stall = cpu_req && dbg_win;
    assign oor_flag  = oor_flag_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_err   = dbg_err_q;
    assign dbg_rdata = dbg_rdata_q;
    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized CPU/debug traffic
// checked against a transaction-order memory model and cycle-count grant rules.
`timescale 1ns/1ps
module tb_data_mem_arbiter;

    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 11;
    localparam int ADDR_LIMIT = 10;
    localparam int MAX_WAIT   = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_rd, cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_stall, oor_flag;
    logic              dbg_req, dbg_we, dbg_ack, dbg_err;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    // Memory environment: latches on negedge, read data appears in the same cycle.
    logic [DATA_W-1:0] mem_arr [0:ADDR_LIMIT-1] = '{default: '0};
    logic [DATA_W-1:0] mem_out = '0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_wr && int'(mem_addr) < ADDR_LIMIT) mem_arr[int'(mem_addr)] <= mem_wdata;
        if (mem_rd && int'(mem_addr) < ADDR_LIMIT) mem_out <= mem_arr[int'(mem_addr)];
    end
    assign mem_rdata = mem_out;

    data_mem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_LIMIT(ADDR_LIMIT), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .oor_flag(oor_flag),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    endtask

    task automatic test_reset();
        logic [2*ADDR_W+3*DATA_W:0] all_out;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            cpu_rd = 1'($urandom_range(0, 1)); cpu_wr = 1'($urandom_range(0, 1));
            cpu_addr = ADDR_W'($urandom_range(0, 15)); cpu_wdata = DATA_W'($urandom);
            dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
            dbg_addr = ADDR_W'($urandom_range(0, 15)); dbg_wdata = DATA_W'($urandom);
        end
        #1;
        all_out = {mem_rd, mem_wr, mem_addr, mem_wdata, dbg_ack, dbg_err, dbg_rdata,
                   oor_flag, cpu_stall};
        n_cmp++;
        if (all_out !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got %h want 0", all_out);
        end
        reset = 1'b0;
        idle_inputs();
        step();
        #1;
        n_cmp++;
        if ({mem_rd, mem_wr, cpu_stall} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release rd/wr/stall got %b want 000", {mem_rd, mem_wr, cpu_stall});
        end
        $display("test_reset done");
    endtask

    task automatic test_dbg_write_read();
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11'd3; dbg_wdata = 16'hBEEF;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL dbgwr_stall got %b want 0", cpu_stall); end
        step(); #1;
        n_cmp++;
        if ({mem_rd, mem_wr} !== 2'b01 || mem_addr !== 11'd3 || mem_wdata !== 16'hBEEF || dbg_ack !== 1'b0) begin
            n_err++;
            $display("FAIL dbgwr_issue rd/wr=%b addr=%0d wdata=%h ack=%b want 01/3/beef/0",
                     {mem_rd, mem_wr}, mem_addr, mem_wdata, dbg_ack);
        end
        step(); #1;
        n_cmp++;
        if (dbg_ack !== 1'b1 || dbg_err !== 1'b0) begin
            n_err++; $display("FAIL dbgwr_ack ack/err got %b%b want 10", dbg_ack, dbg_err);
        end
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'd3;
        #1;
        n_cmp++;
        if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL dbgwr_ack_clear got %b want 0", dbg_ack); end
        step(); #1;
        n_cmp++;
        if ({mem_rd, mem_wr} !== 2'b10 || mem_addr !== 11'd3) begin
            n_err++; $display("FAIL dbgrd_issue rd/wr=%b addr=%0d want 10/3", {mem_rd, mem_wr}, mem_addr);
        end
        step(); #1;
        n_cmp++;
        if (dbg_ack !== 1'b1 || dbg_err !== 1'b0 || dbg_rdata !== 16'hBEEF) begin
            n_err++;
            $display("FAIL dbgrd_ack ack=%b err=%b rdata=%h want 1/0/beef", dbg_ack, dbg_err, dbg_rdata);
        end
        dbg_req = 1'b0;
        $display("test_dbg_write_read done");
    endtask

    task automatic test_contention();
        int k;
        int rel;
        logic [ADDR_W-1:0] held_addr;
        k = 0;
        held_addr = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            rel = c - 2;
            cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = ADDR_W'(k % 8);
            if (rel == 0) begin dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'd3; end
            if (rel == 4) held_addr = cpu_addr;
            #1;
            n_cmp++;
            if (cpu_stall !== (rel == 4)) begin
                n_err++; $display("FAIL contention_stall rel=%0d got %b want %b", rel, cpu_stall, rel == 4);
            end
            if (rel == 5) begin
                n_cmp++;
                if (mem_rd !== 1'b1 || mem_addr !== 11'd3 || dbg_ack !== 1'b0) begin
                    n_err++; $display("FAIL contention_dbg_access rd=%b addr=%0d ack=%b want 1/3/0", mem_rd, mem_addr, dbg_ack);
                end
            end
            if (rel == 6) begin
                n_cmp++;
                if (dbg_ack !== 1'b1 || dbg_rdata !== 16'hBEEF || mem_rd !== 1'b1 || mem_addr !== held_addr) begin
                    n_err++;
                    $display("FAIL contention_ack ack=%b rdata=%h rd=%b addr=%0d want 1/beef/1/%0d",
                             dbg_ack, dbg_rdata, mem_rd, mem_addr, held_addr);
                end
                dbg_req = 1'b0;
            end
            if (rel != 4) k++;
        end
        idle_inputs();
        $display("test_contention done");
    endtask

    task automatic test_dbg_oor();
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'd12;
        step(); #1;
        n_cmp++;
        if ({mem_rd, mem_wr} !== 2'b00 || dbg_ack !== 1'b0) begin
            n_err++; $display("FAIL dbgoor_issue rd/wr=%b ack=%b want 00/0", {mem_rd, mem_wr}, dbg_ack);
        end
        step(); #1;
        n_cmp++;
        if (dbg_ack !== 1'b1 || dbg_err !== 1'b1 || dbg_rdata !== '0) begin
            n_err++; $display("FAIL dbgoor_ack ack=%b err=%b rdata=%h want 1/1/0", dbg_ack, dbg_err, dbg_rdata);
        end
        dbg_req = 1'b0;
        $display("test_dbg_oor done");
    endtask

    task automatic test_cpu_corners();
        step();
        cpu_rd = 1'b1; cpu_wr = 1'b1; cpu_addr = 11'd2;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL both_stall got %b want 0", cpu_stall); end
        step();
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'd15;
        #1;
        n_cmp++;
        if ({mem_rd, mem_wr, cpu_stall, oor_flag} !== 4'b0000) begin
            n_err++; $display("FAIL both_noop rd/wr/stall/oor got %b want 0000", {mem_rd, mem_wr, cpu_stall, oor_flag});
        end
        step();
        cpu_addr = 11'd4;
        #1;
        n_cmp++;
        if ({mem_rd, mem_wr, oor_flag} !== 3'b001) begin
            n_err++; $display("FAIL cpu_oor rd/wr/oor got %b want 001", {mem_rd, mem_wr, oor_flag});
        end
        step();
        idle_inputs();
        #1;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 11'd4 || oor_flag !== 1'b1) begin
            n_err++; $display("FAIL cpu_read_after_oor rd=%b addr=%0d oor=%b want 1/4/1", mem_rd, mem_addr, oor_flag);
        end
        step(); #1;
        n_cmp++;
        if (oor_flag !== 1'b1) begin n_err++; $display("FAIL oor_sticky got %b want 1", oor_flag); end
        $display("test_cpu_corners done");
    endtask

    task automatic test_reset_mid_dbg();
        logic [2*ADDR_W+3*DATA_W:0] all_out;
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 11'd0; dbg_wdata = 16'h5A5A;
        step();
        step();
        dbg_req = 1'b0;
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'd0;
        step(); #1;
        n_cmp++;
        if (mem_rd !== 1'b1) begin n_err++; $display("FAIL rstmid_issue rd got %b want 1", mem_rd); end
        reset = 1'b1; dbg_req = 1'b0;
        step();
        reset = 1'b0;
        #1;
        all_out = {mem_rd, mem_wr, mem_addr, mem_wdata, dbg_ack, dbg_err, dbg_rdata,
                   oor_flag, cpu_stall};
        n_cmp++;
        if (all_out !== '0) begin n_err++; $display("FAIL rstmid_outputs got %h want 0", all_out); end
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 11'd0;
        #1;
        n_cmp++;
        if (dbg_ack !== 1'b0) begin n_err++; $display("FAIL rstmid_no_ack got %b want 0", dbg_ack); end
        step(); #1;
        n_cmp++;
        if (mem_rd !== 1'b1 || mem_addr !== 11'd0 || dbg_ack !== 1'b0) begin
            n_err++; $display("FAIL rstmid_fresh_issue rd=%b addr=%0d ack=%b want 1/0/0", mem_rd, mem_addr, dbg_ack);
        end
        step(); #1;
        n_cmp++;
        if (dbg_ack !== 1'b1 || dbg_err !== 1'b0 || dbg_rdata !== 16'h5A5A) begin
            n_err++; $display("FAIL rstmid_fresh_ack ack=%b err=%b rdata=%h want 1/0/5a5a", dbg_ack, dbg_err, dbg_rdata);
        end
        dbg_req = 1'b0;
        $display("test_reset_mid_dbg done");
    endtask

    // Reference: ops take effect in acceptance order; debug grant follows cycle-count rules.
    task automatic test_random();
        logic [DATA_W-1:0] ref_mem [0:ADDR_LIMIT-1];
        int cyc, next_ok, ack_due, contended, sel;
        logic exp_rd, exp_wr, exp_rv, nxt_rd, nxt_wr, nxt_rv;
        logic [ADDR_W-1:0] exp_addr, nxt_addr;
        logic [DATA_W-1:0] exp_wdata, nxt_wdata, exp_rval, nxt_rval, exp_drdata;
        logic exp_derr, exp_oor, dbg_active, prev_stall, quiet;
        logic req, eligible, win, e_stall, e_ack, oor;
        for (int a = 0; a < ADDR_LIMIT; a++) ref_mem[a] = mem_arr[a];
        cyc = 0; next_ok = 0; ack_due = -10; contended = 0;
        exp_rd = 1'b0; exp_wr = 1'b0; exp_rv = 1'b0; exp_addr = '0; exp_wdata = '0; exp_rval = '0;
        exp_drdata = '0; exp_derr = 1'b0; exp_oor = 1'b0; dbg_active = 1'b0; prev_stall = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step();
            quiet = (i >= 1470);
            if (!prev_stall) begin
                sel = $urandom_range(0, 19);
                cpu_addr = ADDR_W'($urandom_range(0, ADDR_LIMIT + 2));
                cpu_wdata = DATA_W'($urandom);
                if (quiet || sel >= 14) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
                else if (sel == 13) begin cpu_rd = 1'b1; cpu_wr = 1'b1; end
                else if (sel < 7) begin cpu_rd = 1'b1; cpu_wr = 1'b0; end
                else begin cpu_rd = 1'b0; cpu_wr = 1'b1; end
            end
            if (ack_due == cyc) begin
                if (quiet || $urandom_range(0, 1) == 0) begin dbg_req = 1'b0; dbg_active = 1'b0; end
                else dbg_active = 1'b1;
            end else if (!dbg_active && !quiet && $urandom_range(0, 3) == 0) begin
                dbg_active = 1'b1; dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
                dbg_addr = ADDR_W'($urandom_range(0, ADDR_LIMIT + 3)); dbg_wdata = DATA_W'($urandom);
            end
            #1;
            n_cmp++;
            if (mem_rd !== exp_rd || mem_wr !== exp_wr || ((exp_rd || exp_wr) && mem_addr !== exp_addr)
                || (exp_wr && mem_wdata !== exp_wdata)) begin
                n_err++;
                $display("FAIL rand_mem_pins cyc=%0d rd/wr=%b addr=%0d wdata=%h want %b/%0d/%h",
                         cyc, {mem_rd, mem_wr}, mem_addr, mem_wdata, {exp_rd, exp_wr}, exp_addr, exp_wdata);
            end
            e_ack = (ack_due == cyc);
            n_cmp++;
            if (dbg_ack !== e_ack || (e_ack && (dbg_err !== exp_derr || dbg_rdata !== exp_drdata))) begin
                n_err++;
                $display("FAIL rand_dbg_ack cyc=%0d ack=%b err=%b rdata=%h want %b/%b/%h",
                         cyc, dbg_ack, dbg_err, dbg_rdata, e_ack, exp_derr, exp_drdata);
            end
            n_cmp++;
            if (oor_flag !== exp_oor) begin
                n_err++; $display("FAIL rand_oor_flag cyc=%0d got %b want %b", cyc, oor_flag, exp_oor);
            end
            req = cpu_rd ^ cpu_wr;
            eligible = dbg_req && (cyc >= next_ok);
            win = eligible && (!req || contended == MAX_WAIT);
            e_stall = req && win;
            n_cmp++;
            if (cpu_stall !== e_stall) begin
                n_err++; $display("FAIL rand_stall cyc=%0d got %b want %b", cyc, cpu_stall, e_stall);
            end
            if (!dbg_req || win) contended = 0;
            else if (eligible && req && contended < MAX_WAIT) contended++;
            nxt_rd = 1'b0; nxt_wr = 1'b0; nxt_rv = 1'b0;
            nxt_addr = exp_addr; nxt_wdata = exp_wdata; nxt_rval = exp_rval;
            if (win) begin
                oor = (int'(dbg_addr) >= ADDR_LIMIT);
                next_ok = cyc + 3; ack_due = cyc + 2;
                exp_derr = oor; exp_drdata = '0;
                nxt_addr = dbg_addr; nxt_wdata = dbg_wdata;
                if (!oor && dbg_we) begin ref_mem[int'(dbg_addr)] = dbg_wdata; nxt_wr = 1'b1; end
                else if (!oor) begin exp_drdata = ref_mem[int'(dbg_addr)]; nxt_rd = 1'b1; end
            end else if (req) begin
                oor = (int'(cpu_addr) >= ADDR_LIMIT);
                nxt_addr = cpu_addr; nxt_wdata = cpu_wdata;
                if (oor) exp_oor = 1'b1;
                else if (cpu_wr) begin ref_mem[int'(cpu_addr)] = cpu_wdata; nxt_wr = 1'b1; end
                else begin nxt_rd = 1'b1; nxt_rv = 1'b1; nxt_rval = ref_mem[int'(cpu_addr)]; end
            end
            prev_stall = e_stall;
            #5;
            if (exp_rv) begin
                n_cmp++;
                if (cpu_rdata !== exp_rval) begin
                    n_err++; $display("FAIL rand_cpu_rdata cyc=%0d got %h want %h", cyc, cpu_rdata, exp_rval);
                end
            end
            exp_rd = nxt_rd; exp_wr = nxt_wr; exp_rv = nxt_rv;
            exp_addr = nxt_addr; exp_wdata = nxt_wdata; exp_rval = nxt_rval;
            cyc++;
        end
        idle_inputs();
        $display("test_random done after %0d cycles", cyc);
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_dbg_write_read();
        test_contention();
        test_dbg_oor();
        test_cpu_corners();
        test_reset_mid_dbg();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the BIP single-port data memory between two requesters: the BIP CPU (port 0) and the UART debug/loader engine (port 1).
- The CPU has priority. A pending debug request is guaranteed service after at most MAX_WAIT cycles of CPU contention; it takes the slot by stalling the CPU for exactly one cycle.
- Drives the memory's Rd/Wr/Addr/In_data pins from registers. The memory latches on the following negedge and returns Out_data within the same cycle.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 11, address width.
- ADDR_LIMIT, 10, number of implemented words. Addresses >= ADDR_LIMIT are out of range.
- MAX_WAIT, 4, maximum contended cycles before debug preempts the CPU (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_rd  in  1  CPU read request.
- cpu_wr  in  1  CPU write request.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  combinational copy of mem_rdata.
- cpu_stall  out  1  combinational; CPU request not accepted this cycle.
- oor_flag  out  1  sticky; CPU issued an out-of-range access.
- dbg_req  in  1  debug request level. Fields held stable until dbg_ack.
- dbg_we  in  1  1 = write, 0 = read.
- dbg_addr  in  ADDR_W  debug address.
- dbg_wdata  in  DATA_W  debug write data.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_err  out  1  valid with dbg_ack; address was out of range.
- dbg_rdata  out  DATA_W  read data, valid with dbg_ack and held until the next ack.
- mem_rd  out  1  registered memory Rd.
- mem_wr  out  1  registered memory Wr.
- mem_addr  out  ADDR_W  registered memory Addr.
- mem_wdata  out  DATA_W  registered memory In_data.
- mem_rdata  in  DATA_W  memory Out_data.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high; reset is checked before all other logic.
- Reset values: mem_rd/mem_wr/mem_addr/mem_wdata = 0, dbg_ack = 0, dbg_err = 0, dbg_rdata = 0, oor_flag = 0, wait_cnt = 0, state = RUN.
- Reset mid-access: any in-flight debug access is abandoned and no ack is generated.

CPU request decoding:
- cpu_req = cpu_rd XOR cpu_wr.
- Both asserted is treated as no request: no memory op and no stall.

Debug-win rule (evaluated each cycle):
- dbg_pend = dbg_req AND state == RUN.
- dbg_win = dbg_pend AND (NOT cpu_req OR wait_cnt == MAX_WAIT).

cpu_stall:
- cpu_stall = cpu_req AND dbg_win. It is combinational.
- A stalled CPU holds its request; it is accepted on a later cycle.

wait_cnt:
- Increments in RUN when dbg_pend AND cpu_req AND NOT dbg_win.
- Clears when dbg_win or when NOT dbg_req.
- Saturates at MAX_WAIT.

FSM states:
- RUN: dbg_win -> DBG_ISSUE. In this case the mem_* registers load the debug fields: mem_rd = NOT dbg_we, mem_wr = dbg_we. If dbg_addr >= ADDR_LIMIT, mem_rd = mem_wr = 0 and err_q is set. Otherwise, a valid CPU request loads mem_* from the CPU fields.
- DBG_ISSUE (1 cycle): the memory performs the debug access. At the end of the cycle, dbg_rdata <= mem_rdata (or 0 if err_q or write), dbg_ack <= 1, dbg_err <= err_q, -> DBG_ACK. The CPU may be accepted this cycle; mem_* loads the CPU request for the next cycle.
- DBG_ACK (1 cycle): dbg_ack = 1. No debug grant this cycle, because dbg_req may still be high from the finished transaction. CPU accepted normally. -> RUN; dbg_ack clears.

Idle and out-of-range CPU handling:
- When there is no accepted request, mem_rd = mem_wr = 0. mem_addr and mem_wdata hold their last value.
- CPU out-of-range (cpu_addr >= ADDR_LIMIT): mem_rd = mem_wr = 0 and oor_flag is set. The request is still accepted (no stall).

Latencies:
- CPU request accepted in cycle t -> mem_* valid in t+1 -> cpu_rdata valid by the end of t+1.
- Debug request granted in cycle t -> access in t+1 -> dbg_ack in t+2.
- Worst-case debug wait under continuous CPU traffic: MAX_WAIT + 2 cycles to ack.

Debug handshake:
- dbg_req held high after dbg_ack is seen as a new request in RUN, from t+3 onward.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> every output 0. Then release with no requests -> mem_rd = mem_wr = 0 and state RUN.
- Idle-CPU debug write then read: dbg_req, we=1, addr 3, data 0xBEEF in cycle t -> mem_wr=1, mem_addr=3, mem_wdata=0xBEEF in t+1; dbg_ack=1 in t+2, dbg_err=0. Then read addr 3 -> dbg_rdata=0xBEEF with ack.
- Contention, MAX_WAIT=4: CPU reads every cycle, addr 0..7; dbg_req rises at t -> debug wins at t+4 with cpu_stall=1 only in t+4; mem_* carries the debug access in t+5; CPU resumes in t+5; dbg_ack at t+6.
- Out-of-range debug: dbg_req read, addr 12 -> no mem_rd/mem_wr pulse, dbg_ack with dbg_err=1, dbg_rdata=0.
- CPU corner cases: cpu_rd = cpu_wr = 1 -> no memory op, cpu_stall=0. CPU read at addr 15 -> no memory op; oor_flag=1 and stays 1 until reset.
- Reset during DBG_ISSUE: no dbg_ack afterwards, all outputs 0. A fresh debug read of addr 0 then completes normally in 2 cycles.
